conv3x3_mac: RTL and testbench

Pipelined 3x3 multiply-accumulate engine that consumes one 3x3 input window plus its matching 144-bit weight set and 16-bit bias per beat. The weights and bias come from the kernel ROM, addressed by the channel sequencer. The engine accumulates across `i_num_ci` input channels and emits one saturated Q8.8 output pixel per output channel. It sits between the line-buffer/window generator and the output feature-map writer.

---
 rtl/conv_pkg.sv | 14 +
 rtl/mac9_tree.sv | 58 +++++
 rtl/conv3x3_mac.sv | 86 ++++++++
 tb/tb_conv3x3_mac.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, kernel geometry and saturation limits for the conv datapath
package conv_pkg;
   localparam int DATA_W      = 16;
   localparam int FRAC_W      = 8;
   localparam int ACC_W       = 48;
   localparam int KERNEL_TAPS = 9;
   localparam int TAPS_W      = KERNEL_TAPS * DATA_W;
   localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
   localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;
   // Low bit of tap k within a packed window/weight bus (k=0 top-left, row-major)
   function automatic int tap_lo(input int k);
      return k * DATA_W;
   endfunction
endpackage

// File: rtl/mac9_tree.sv
// mac9_tree: beat register, 9 signed products and their adder-tree sum, with flag passthrough
// Ports: i_clk/i_rstn clock and sync active-low reset; en advances all stages;
//        valid/first/last/bias/window/weight describe the accepted beat;
//        sum_* present the registered tap sum three edges later.
module mac9_tree import conv_pkg::*; #(
   parameter int DW = conv_pkg::DATA_W
) (
   input  logic                       i_clk,
   input  logic                       i_rstn,
   input  logic                       en,
   input  logic                       valid,
   input  logic                       first,
   input  logic                       last,
   input  logic signed [DW-1:0]       bias,
   input  logic [KERNEL_TAPS*DW-1:0]  window,
   input  logic [KERNEL_TAPS*DW-1:0]  weight,
   output logic                       sum_valid,
   output logic                       sum_first,
   output logic                       sum_last,
   output logic signed [DW-1:0]       sum_bias,
   output logic signed [2*DW+3:0]     sum
);
   localparam int PW = 2 * DW;
   localparam int SW = PW + 4;
   logic [2:0] v, f, l;
   logic signed [DW-1:0] b0, b1, b2;
   logic [KERNEL_TAPS*DW-1:0] win_r, wt_r;
   logic signed [PW-1:0] prod [KERNEL_TAPS];
   logic signed [SW-1:0] tree_sum, sum_r;
   always_ff @(posedge i_clk) begin
      if (!i_rstn) v <= '0;
      else if (en) v <= {v[1:0], valid};
   end
   // The beat is registered before the multipliers so the DSP inputs come straight from flops
   always_ff @(posedge i_clk) begin
      if (en) begin
         f     <= {f[1:0], first};
         l     <= {l[1:0], last};
         b0    <= bias;
         b1    <= b0;
         b2    <= b1;
         win_r <= window;
         wt_r  <= weight;
         for (int k = 0; k < KERNEL_TAPS; k++)
            prod[k] <= $signed(win_r[k*DW +: DW]) * $signed(wt_r[k*DW +: DW]);
         sum_r <= tree_sum;
      end
   end
   always_comb begin
      tree_sum = '0;
      for (int k = 0; k < KERNEL_TAPS; k++) tree_sum = tree_sum + SW'(prod[k]);
   end
   assign sum_valid = v[2];
   assign sum_first = f[2];
   assign sum_last  = l[2];
   assign sum_bias  = b2;
   assign sum       = sum_r;
endmodule

// File: rtl/conv3x3_mac.sv
// conv3x3_mac: 3x3 MAC engine accumulating over input channels, emitting saturated Q8.8 pixels
// Ports: i_clk/i_rstn clock and sync active-low reset; i_num_ci channels per group;
//        i_valid/o_ready input handshake for i_window/i_weight/i_bias;
//        o_valid/i_ready output handshake for o_data.
module conv3x3_mac import conv_pkg::*; #(
   parameter int DATA_W = conv_pkg::DATA_W,
   parameter int FRAC_W = conv_pkg::FRAC_W,
   parameter int ACC_W  = conv_pkg::ACC_W,
   parameter bit RELU   = 1'b0
) (
   input  logic                            i_clk,
   input  logic                            i_rstn,
   input  logic [9:0]                      i_num_ci,
   input  logic                            i_valid,
   output logic                            o_ready,
   input  logic [KERNEL_TAPS*DATA_W-1:0]   i_window,
   input  logic [KERNEL_TAPS*DATA_W-1:0]   i_weight,
   input  logic [DATA_W-1:0]               i_bias,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic [DATA_W-1:0]               o_data
);
   logic en, accept, first, last;
   logic [9:0] ci_cnt, n_lat, n_eff;
   logic s_valid, s_first, s_last;
   logic signed [DATA_W-1:0] s_bias;
   logic signed [2*DATA_W+3:0] s_sum;
   logic signed [ACC_W-1:0] acc, acc_base, acc_next, shifted;
   logic [ACC_W-DATA_W:0] hi;
   logic ovf;
   logic [DATA_W-1:0] sat, res;
   assign en      = !(o_valid && !i_ready);
   assign o_ready = en;
   assign accept  = i_valid && en;
   assign first   = ci_cnt == 10'd0;
   // The group size is taken live on the first beat so an n=1 group can end on that same beat
   assign n_eff   = first ? (i_num_ci == 10'd0 ? 10'd1 : i_num_ci) : n_lat;
   assign last    = ci_cnt == n_eff - 10'd1;
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         ci_cnt <= '0;
         n_lat  <= 10'd1;
      end else if (accept) begin
         ci_cnt <= last ? 10'd0 : ci_cnt + 10'd1;
         if (first) n_lat <= n_eff;
      end
   end
   mac9_tree #(.DW(DATA_W)) u_tree (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .en        (en),
      .valid     (accept),
      .first     (first),
      .last      (last),
      .bias      (i_bias),
      .window    (i_window),
      .weight    (i_weight),
      .sum_valid (s_valid),
      .sum_first (s_first),
      .sum_last  (s_last),
      .sum_bias  (s_bias),
      .sum       (s_sum)
   );
   // Overflow when the bits above the Q8.8 sign bit disagree with it
   always_comb begin
      acc_base = s_first ? ACC_W'(s_bias) <<< FRAC_W : acc;
      acc_next = acc_base + ACC_W'(s_sum);
      shifted  = acc_next >>> FRAC_W;
      hi       = shifted[ACC_W-1:DATA_W-1];
      ovf      = !(&hi || ~|hi);
      sat      = ovf ? (hi[ACC_W-DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}})
                     : shifted[DATA_W-1:0];
      res      = (RELU && sat[DATA_W-1]) ? '0 : sat;
   end
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         acc     <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
      end else if (en) begin
         o_valid <= s_valid && s_last;
         if (s_valid) acc <= s_last ? '0 : acc_next;
         if (s_valid && s_last) o_data <= res;
      end
   end
endmodule

// File: tb/tb_conv3x3_mac.sv
// tb_conv3x3_mac: directed scoreboard bench for conv3x3_mac (plain and RELU instances)
module tb_conv3x3_mac;
   logic i_clk = 1'b0;
   logic i_rstn;
   logic [9:0] i_num_ci;
   logic i_valid, i_ready;
   logic [143:0] i_window, i_weight;
   logic [15:0] i_bias;
   logic o_ready, o_valid, o_ready_r, o_valid_r;
   logic [15:0] o_data, o_data_r;
   logic [15:0] exp_q [$];
   int checks = 0;
   int errors = 0;

   always #5 i_clk = ~i_clk;

   conv3x3_mac u_dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_num_ci(i_num_ci), .i_valid(i_valid), .o_ready(o_ready),
      .i_window(i_window), .i_weight(i_weight), .i_bias(i_bias),
      .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data)
   );
   conv3x3_mac #(.RELU(1'b1)) u_relu (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_num_ci(i_num_ci), .i_valid(i_valid), .o_ready(o_ready_r),
      .i_window(i_window), .i_weight(i_weight), .i_bias(i_bias),
      .o_valid(o_valid_r), .i_ready(i_ready), .o_data(o_data_r)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [143:0] fill(input logic [15:0] x);
      return {9{x}};
   endfunction

   function automatic logic [143:0] one_tap(input int k, input logic [15:0] x);
      logic [143:0] r;
      r = '0;
      r[k*16 +: 16] = x;
      return r;
   endfunction

   // Scoreboard monitor: a handshake happens at the next edge whenever o_valid && i_ready here
   always @(negedge i_clk) begin
      if (i_rstn && o_valid && i_ready) begin
         if (exp_q.size() == 0) check("unexpected_out", {16'h0, o_data}, 32'hDEAD_BEEF);
         else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            check("out", {16'h0, o_data}, {16'h0, e});
            check("out_relu", {16'h0, o_data_r}, {16'h0, e[15] ? 16'h0 : e});
         end
      end
   end

   task automatic beat(input logic [143:0] w, input logic [143:0] wt, input logic [15:0] b, input logic [9:0] n);
      logic ok;
      i_valid = 1'b1; i_window = w; i_weight = wt; i_bias = b; i_num_ci = n;
      for (int t = 0; t < 60; t++) begin
         @(negedge i_clk) ok = o_ready;
         @(posedge i_clk) #1;
         if (ok) return;
      end
      check("accept_timeout", 32'h0, 32'h1);
   endtask

   task automatic drain();
      i_valid = 1'b0;
      for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge i_clk);
      check("drain", exp_q.size(), 0);
      @(posedge i_clk) #1;
   endtask

   initial begin
      i_rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_num_ci = '0;
      i_window = '0; i_weight = '0; i_bias = '0;
      repeat (3) @(posedge i_clk);
      #1 i_rstn = 1'b1;
      @(negedge i_clk);
      check("rst_o_valid", o_valid, 0);
      check("rst_o_data", o_data, 0);
      check("rst_o_ready", o_ready, 1);
      @(posedge i_clk) #1;
      // unit kernel: 9 x 1.0 x 1.0 = 9.0, then latency
      exp_q.push_back(16'h0900);
      beat(fill(16'h0100), fill(16'h0100), 16'h0, 10'd1);
      i_valid = 1'b0;
      @(negedge i_clk) check("lat_t0", o_valid, 0);
      @(negedge i_clk) check("lat_t1", o_valid, 0);
      @(negedge i_clk) check("lat_t2", o_valid, 0);
      @(negedge i_clk) check("lat_t3", o_valid, 1);
      @(posedge i_clk) #1;
      drain();
      // three channels x 2.0 + 0.5 bias; later-beat bias and i_num_ci ignored
      exp_q.push_back(16'h0680);
      beat(fill(16'h0100), one_tap(4, 16'h0200), 16'h0080, 10'd3);
      beat(fill(16'h0100), one_tap(4, 16'h0200), 16'h7FFF, 10'd1);
      beat(fill(16'h0100), one_tap(4, 16'h0200), 16'h7FFF, 10'd0);
      drain();
      // saturation both ways (RELU instance clamps the negative one to 0)
      exp_q.push_back(16'h7FFF);
      beat(fill(16'h7FFF), fill(16'h7FFF), 16'h0, 10'd1);
      exp_q.push_back(16'h8000);
      beat(fill(16'h7FFF), fill(16'h8001), 16'h0, 10'd1);
      drain();
      // floor on the arithmetic shift
      exp_q.push_back(16'h0000);
      beat(one_tap(0, 16'h0001), one_tap(0, 16'h0001), 16'h0, 10'd1);
      exp_q.push_back(16'hFFFF);
      beat(one_tap(0, 16'h0001), one_tap(0, 16'hFFFF), 16'h0, 10'd1);
      drain();
      // backpressure: four n=1 groups while the sink stalls
      i_ready = 1'b0;
      for (int g = 1; g <= 4; g++) begin
         exp_q.push_back(16'(g << 8));
         beat(fill(16'h0100), one_tap(0, 16'(g << 8)), 16'h0, 10'd1);
      end
      i_valid = 1'b0;
      for (int t = 0; t < 20 && !o_valid; t++) @(negedge i_clk);
      check("bp_first_valid", o_valid, 1);
      for (int t = 0; t < 5; t++) begin
         check("bp_o_ready", o_ready, 0);
         check("bp_o_data_hold", o_data, 16'h0100);
         @(negedge i_clk);
      end
      @(posedge i_clk) #1 i_ready = 1'b1;
      for (int t = 0; t < 4; t++) @(negedge i_clk) check("bp_stream_valid", o_valid, 1);
      @(posedge i_clk) #1;
      drain();
      // reset in the middle of an n=4 group
      beat(fill(16'h0100), fill(16'h0100), 16'h0, 10'd4);
      beat(fill(16'h0100), fill(16'h0100), 16'h0, 10'd4);
      i_valid = 1'b0;
      i_rstn = 1'b0;
      @(posedge i_clk) #1 i_rstn = 1'b1;
      @(negedge i_clk);
      check("rstmid_o_valid", o_valid, 0);
      check("rstmid_o_data", o_data, 0);
      @(posedge i_clk) #1;
      exp_q.push_back(16'h0900);
      beat(fill(16'h0100), fill(16'h0100), 16'h0, 10'd1);
      drain();
      repeat (6) @(negedge i_clk);
      check("final_idle", o_valid, 0);
      check("final_queue", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
